stg_2_id: RTL

Instruction-decode stage of the Luka pipeline. It sits directly downstream of the fetch stage and consumes its `r_id_instr` register. It decodes the 19-bit instruction, reads two operands from an 8-entry register file with same-cycle write-back bypass, and detects load-use hazards. Decoded fields are registered into the `r_ex_*` pipeline registers for the execute stage. After reset it zero-clears the register file with a sequential sweep before accepting instructions.

---
 rtl/stg_2_id.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/stg_2_id.sv
// Luka pipeline instruction-decode stage: decode, register read with write-back bypass,
// load-use stall and register-file sweep after reset.
// Ports: clock/reset; r_id_instr in; wb_* write-back in; id_stall, r_ex_* and r_id_illegal out.
module stg_2_id #(
  parameter  int INSTR_W  = 19,
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 8,
  localparam int REG_W    = $clog2(NUM_REGS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] r_id_instr,
  input  logic               wb_en,
  input  logic [REG_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               id_stall,
  output logic               r_ex_valid,
  output logic [3:0]         r_ex_op,
  output logic [REG_W-1:0]   r_ex_rd,
  output logic [DATA_W-1:0]  r_ex_a,
  output logic [DATA_W-1:0]  r_ex_b,
  output logic [DATA_W-1:0]  r_ex_imm,
  output logic               r_ex_we,
  output logic               r_id_illegal
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LOAD = 4'd7;
  localparam logic [3:0] OP_ST   = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [REG_W-1:0]   r_clr_idx;
  logic [REG_W-1:0]   w_clr_nxt;
  logic [DATA_W-1:0]  r_rf [NUM_REGS];

  logic [3:0]         w_op;
  logic [REG_W-1:0]   w_rd;
  logic [REG_W-1:0]   w_rs1;
  logic [REG_W-1:0]   w_rs2;
  logic               w_use1;
  logic               w_use2;
  logic               w_we;
  logic               w_legal;
  logic [DATA_W-1:0]  w_imm;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic               w_hazard;

  assign w_op  = r_id_instr[18:15];
  assign w_rd  = r_id_instr[14:12];
  assign w_rs1 = r_id_instr[11:9];
  assign w_rs2 = r_id_instr[8:6];

  always_comb begin
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_we    = 1'b0;
    w_legal = 1'b1;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_we   = 1'b1;
      end
      OP_ADDI, OP_LOAD: begin
        w_use1 = 1'b1;
        w_we   = 1'b1;
      end
      OP_ST, OP_BEQ: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      OP_NOP, OP_JMP: ;
      default: begin
        // unknown encodings are treated as reading both
        // sources so a pending load still stalls them
        w_legal = 1'b0;
        w_use1  = 1'b1;
        w_use2  = 1'b1;
      end
    endcase
  end

  assign w_imm = (w_op == OP_JMP) ?
    {{(DATA_W-12){r_id_instr[11]}}, r_id_instr[11:0]} :
    {{(DATA_W-6){r_id_instr[5]}}, r_id_instr[5:0]};

  always_comb begin
    if (w_rs1 == '0)
      w_a = '0;
    else if (wb_en && wb_addr == w_rs1)
      w_a = wb_data;
    else
      w_a = r_rf[w_rs1];
  end

  always_comb begin
    if (w_rs2 == '0)
      w_b = '0;
    else if (wb_en && wb_addr == w_rs2)
      w_b = wb_data;
    else
      w_b = r_rf[w_rs2];
  end

  assign w_hazard = (r_state == S_RUN) && r_ex_valid &&
                    (r_ex_op == OP_LOAD) && (r_ex_rd != '0) &&
                    ((w_use1 && r_ex_rd == w_rs1) ||
                     (w_use2 && r_ex_rd == w_rs2));

  assign id_stall = (r_state == S_CLEAR) || w_hazard;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_idx;
    case (r_state)
      S_CLEAR: begin
        w_clr_nxt = r_clr_idx + 1'b1;
        if (r_clr_idx == REG_W'(NUM_REGS-1)) begin
          w_state_nxt = S_RUN;
          w_clr_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == S_CLEAR)
        r_rf[r_clr_idx] <= '0;
      else if (wb_en && wb_addr != '0)
        r_rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || id_stall || !w_legal) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_rd    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_imm   <= '0;
      r_ex_we    <= 1'b0;
    end else begin
      r_ex_valid <= 1'b1;
      r_ex_op    <= w_op;
      r_ex_rd    <= w_rd;
      r_ex_a     <= w_a;
      r_ex_b     <= w_b;
      r_ex_imm   <= w_imm;
      r_ex_we    <= w_we && (w_rd != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_id_illegal <= 1'b0;
    else if (!id_stall && !w_legal)
      r_id_illegal <= 1'b1;
  end

endmodule
